// File: rtl/except_ctrl.sv
// MEM-stage exception controller: interrupt sync, CP0 forwarding,
// exception prioritisation, flush/redirect and post-flush blanking.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_o,
  input  logic        inst_valid_i,
  input  logic        stall_i,
  input  logic [31:0] inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic        syscall_i,
  input  logic        inst_invalid_i,
  input  logic        trap_i,
  input  logic        ov_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] epc_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic {IDLE, BLANK} state_e;

  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  sync1_q, int_q;
  logic [31:0] status_fwd, cause_fwd, epc_fwd;
  logic        wb_status, wb_cause, wb_epc;
  logic        int_pend, accept;
  logic        unused_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      int_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= int_i;
      int_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign int_o = int_q;

  assign wb_status = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12);
  assign wb_cause  = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13);
  assign wb_epc    = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14);

  assign status_fwd = wb_status ? wb_cp0_data_i : cp0_status_i;
  assign epc_fwd    = wb_epc ? wb_cp0_data_i : cp0_epc_i;

  // Only the software-writable Cause fields are taken from WB.
  always_comb begin
    cause_fwd = cp0_cause_i;
    if (wb_cause) begin
      cause_fwd[9:8]   = wb_cp0_data_i[9:8];
      cause_fwd[23:22] = wb_cp0_data_i[23:22];
    end
  end

  assign unused_ok = ^{status_fwd[31:16], status_fwd[7:2],
                       cause_fwd[31:16], cause_fwd[7:0]};

  assign int_pend = ((cause_fwd[15:8] & status_fwd[15:8]) != 8'h0)
                  && status_fwd[0] && !status_fwd[1];

  assign accept = !rst && (state_q == IDLE)
                && inst_valid_i && !stall_i;

  always_comb begin
    excepttype_o = 32'h0;
    if (accept) begin
      if (int_pend)            excepttype_o = 32'h1;
      else if (syscall_i)      excepttype_o = 32'h8;
      else if (inst_invalid_i) excepttype_o = 32'ha;
      else if (trap_i)         excepttype_o = 32'hd;
      else if (ov_i)           excepttype_o = 32'hc;
      else if (eret_i)         excepttype_o = 32'he;
    end
  end

  assign flush_o = (excepttype_o != 32'h0);

  always_comb begin
    new_pc_o = 32'h0;
    if (excepttype_o == 32'he) new_pc_o = epc_fwd;
    else if (flush_o)          new_pc_o = EXC_VECTOR;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flush_o) begin
          state_d = BLANK;
          cnt_d   = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign current_inst_addr_o = inst_addr_i;
  assign is_in_delayslot_o   = is_in_delayslot_i;
  assign epc_o               = epc_fwd;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i, int_o;
  logic        inst_valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] inst_addr_i;
  logic        syscall_i, inst_invalid_i, trap_i, ov_i, eret_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, current_inst_addr_o, epc_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  except_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i), .int_o(int_o),
    .inst_valid_i(inst_valid_i), .stall_i(stall_i),
    .inst_addr_i(inst_addr_i),
    .is_in_delayslot_i(is_in_delayslot_i),
    .syscall_i(syscall_i), .inst_invalid_i(inst_invalid_i),
    .trap_i(trap_i), .ov_i(ov_i), .eret_i(eret_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
    .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .epc_o(epc_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  task automatic clear_inputs();
    int_i = '0; inst_valid_i = 0; stall_i = 0;
    inst_addr_i = '0; is_in_delayslot_i = 0;
    syscall_i = 0; inst_invalid_i = 0; trap_i = 0;
    ov_i = 0; eret_i = 0;
    cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
    wb_cp0_we_i = 0; wb_cp0_waddr_i = '0; wb_cp0_data_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the two blanking cycles after a flush elapse.
  task automatic drain();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    int_i = 6'h3f;
    inst_valid_i = 1; syscall_i = 1;
    cp0_epc_i = 32'h55;
    tick(); tick(); tick();
    #1;
    checks++;
    if (int_o !== 6'h0) begin
      failures++; $display("FAIL reset_int_o got=%h exp=0", int_o);
    end
    checks++;
    if (excepttype_o !== 32'h0 || flush_o !== 1'b0 || new_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outs type=%h flush=%b pc=%h exp=0", excepttype_o, flush_o, new_pc_o);
    end
    checks++;
    if (epc_o !== 32'h55) begin
      failures++; $display("FAIL reset_epc got=%h exp=55", epc_o);
    end
    clear_inputs();
    rst = 0;
  endtask

  task automatic test_syscall();
    tick();
    syscall_i = 1; inst_valid_i = 1;
    inst_addr_i = 32'h80000100; is_in_delayslot_i = 1;
    #1;
    checks++;
    if (excepttype_o !== 32'h8 || flush_o !== 1'b1 || new_pc_o !== 32'h20) begin
      failures++;
      $display("FAIL syscall type=%h flush=%b pc=%h exp 8/1/20", excepttype_o, flush_o, new_pc_o);
    end
    checks++;
    if (current_inst_addr_o !== 32'h80000100 || is_in_delayslot_o !== 1'b1) begin
      failures++;
      $display("FAIL syscall_addr got=%h ds=%b exp=80000100/1", current_inst_addr_o, is_in_delayslot_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin
        failures++;
        $display("FAIL syscall_blank%0d type=%h flush=%b exp=0", i, excepttype_o, flush_o);
      end
    end
    tick();
    checks++;
    if (excepttype_o !== 32'h8) begin
      failures++; $display("FAIL syscall_after_blank got=%h exp=8", excepttype_o);
    end
    drain();
  endtask

  task automatic test_interrupt();
    tick();
    int_i = 6'h01;
    #1;
    checks++;
    if (int_o !== 6'h0) begin
      failures++; $display("FAIL int_sync0 got=%h exp=0", int_o);
    end
    tick();
    checks++;
    if (int_o !== 6'h0) begin
      failures++; $display("FAIL int_sync1 got=%h exp=0", int_o);
    end
    tick();
    checks++;
    if (int_o !== 6'h01) begin
      failures++; $display("FAIL int_sync2 got=%h exp=01", int_o);
    end
    cp0_status_i = 32'h0; cp0_cause_i = 32'h400;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd12;
    wb_cp0_data_i = 32'h401;
    inst_valid_i = 1; inst_addr_i = 32'h80000200;
    #1;
    checks++;
    if (excepttype_o !== 32'h1 || new_pc_o !== 32'h20) begin
      failures++; $display("FAIL int_fwd_status type=%h pc=%h exp 1/20", excepttype_o, new_pc_o);
    end
    drain();
  endtask

  task automatic test_int_masking();
    // EXL set: interrupt must be ignored.
    tick();
    cp0_status_i = 32'h403; cp0_cause_i = 32'h400;
    inst_valid_i = 1;
    #1;
    checks++;
    if (excepttype_o !== 32'h0) begin
      failures++; $display("FAIL int_exl got=%h exp=0", excepttype_o);
    end
    // WB cannot forward hardware IP bits of Cause.
    cp0_status_i = 32'h401; cp0_cause_i = 32'h0;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd13;
    wb_cp0_data_i = 32'h400;
    #1;
    checks++;
    if (excepttype_o !== 32'h0) begin
      failures++; $display("FAIL cause_ip_hw got=%h exp=0", excepttype_o);
    end
    // Software IP1 is forwarded.
    cp0_status_i = 32'h201; wb_cp0_data_i = 32'h200;
    #1;
    checks++;
    if (excepttype_o !== 32'h1) begin
      failures++; $display("FAIL cause_ip_sw got=%h exp=1", excepttype_o);
    end
    drain();
  endtask

  task automatic test_priority();
    logic [4:0]  flags [4];
    logic [31:0] exp [4];
    flags[0] = 5'b11110; exp[0] = 32'h8;
    flags[1] = 5'b01110; exp[1] = 32'ha;
    flags[2] = 5'b00110; exp[2] = 32'hd;
    flags[3] = 5'b00010; exp[3] = 32'hc;
    // Interrupt beats ERET and syscall.
    tick();
    cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    eret_i = 1; syscall_i = 1; inst_valid_i = 1;
    #1;
    checks++;
    if (excepttype_o !== 32'h1 || new_pc_o !== 32'h20) begin
      failures++; $display("FAIL prio_int type=%h pc=%h exp 1/20", excepttype_o, new_pc_o);
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      tick();
      {syscall_i, inst_invalid_i, trap_i, ov_i, eret_i} = flags[i];
      inst_valid_i = 1;
      #1;
      checks++;
      if (excepttype_o !== exp[i]) begin
        failures++; $display("FAIL prio%0d got=%h exp=%h", i, excepttype_o, exp[i]);
      end
      drain();
    end
  endtask

  task automatic test_eret();
    tick();
    eret_i = 1; inst_valid_i = 1;
    cp0_epc_i = 32'h100;
    wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14;
    wb_cp0_data_i = 32'h200;
    #1;
    checks++;
    if (excepttype_o !== 32'he || new_pc_o !== 32'h200 || epc_o !== 32'h200) begin
      failures++;
      $display("FAIL eret_fwd type=%h pc=%h epc=%h exp e/200/200", excepttype_o, new_pc_o, epc_o);
    end
    drain();
    tick();
    eret_i = 1; inst_valid_i = 1; cp0_epc_i = 32'h100;
    #1;
    checks++;
    if (new_pc_o !== 32'h100 || epc_o !== 32'h100) begin
      failures++; $display("FAIL eret_nofwd pc=%h epc=%h exp 100", new_pc_o, epc_o);
    end
    drain();
  endtask

  task automatic test_held_int();
    cp0_status_i = 32'h401; cp0_cause_i = 32'h400;
    for (int i = 0; i < 4; i++) begin
      tick();
      inst_valid_i = 0;
      #1;
      checks++;
      if (excepttype_o !== 32'h0) begin
        failures++; $display("FAIL held_bubble%0d got=%h exp=0", i, excepttype_o);
      end
    end
    tick();
    inst_valid_i = 1;
    #1;
    checks++;
    if (excepttype_o !== 32'h1) begin
      failures++; $display("FAIL held_fire got=%h exp=1", excepttype_o);
    end
    tick();
    checks++;
    if (excepttype_o !== 32'h0) begin
      failures++; $display("FAIL held_once got=%h exp=0", excepttype_o);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      ov_i = 1; inst_valid_i = 1; stall_i = 1;
      #1;
      checks++;
      if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin
        failures++; $display("FAIL stall%0d type=%h flush=%b exp 0", i, excepttype_o, flush_o);
      end
    end
    tick();
    stall_i = 0;
    #1;
    checks++;
    if (excepttype_o !== 32'hc) begin
      failures++; $display("FAIL stall_release got=%h exp=c", excepttype_o);
    end
    tick();
    checks++;
    if (excepttype_o !== 32'h0) begin
      failures++; $display("FAIL stall_once got=%h exp=0", excepttype_o);
    end
    drain();
  endtask

  task automatic test_reset_blank();
    tick();
    ov_i = 1; inst_valid_i = 1;
    #1;
    checks++;
    if (excepttype_o !== 32'hc) begin
      failures++; $display("FAIL rb_flush got=%h exp=c", excepttype_o);
    end
    tick();
    rst = 1;
    #1;
    checks++;
    if (flush_o !== 1'b0) begin
      failures++; $display("FAIL rb_in_reset flush=%b exp=0", flush_o);
    end
    rst = 0;
    #1;
    checks++;
    if (excepttype_o !== 32'hc) begin
      failures++; $display("FAIL rb_after_reset got=%h exp=c", excepttype_o);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_interrupt();
    test_int_masking();
    test_priority();
    test_eret();
    test_held_int();
    test_stall();
    test_reset_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
